// File: rtl/reset_sequencer.sv
// Board reset synchroniser and staged per-domain reset release with software re-sequencing.
// Optional macro RESET_SEQ_CAUSE_EN adds the LastCause output recording the last reset source.
module reset_sequencer #(
   parameter int NUM_DOMAINS   = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int RELEASE_GAP   = 16,
   parameter int HOLD_CYCLES   = 8
) (
   input  logic                   Reset,
   input  logic                   Clock,
   input  logic                   SoftReset,
   output logic [NUM_DOMAINS-1:0] SysReset,
   output logic                   ResetDone
`ifdef RESET_SEQ_CAUSE_EN
   ,
   output logic [1:0]             LastCause
`endif
);

   localparam int MAX_FG    = (FILTER_CYCLES > RELEASE_GAP) ? FILTER_CYCLES : RELEASE_GAP;
   localparam int MAX_COUNT = (MAX_FG > HOLD_CYCLES) ? MAX_FG : HOLD_CYCLES;
   localparam int CW        = $clog2(MAX_COUNT) + 1;
   localparam int IW        = $clog2(NUM_DOMAINS) + 1;

   localparam logic [CW-1:0] FILTER_LAST = CW'(FILTER_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST    = CW'(RELEASE_GAP - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
   localparam logic [IW-1:0] LAST_INDEX  = IW'(NUM_DOMAINS - 1);

   localparam logic [2:0] SYNC      = 3'd0;
   localparam logic [2:0] FILTER    = 3'd1;
   localparam logic [2:0] SEQ       = 3'd2;
   localparam logic [2:0] RUN       = 3'd3;
   localparam logic [2:0] SOFT_HOLD = 3'd4;

   // A single-domain build has nothing left to sequence once domain 0 is out of reset.
   localparam logic [2:0] AFTER_FIRST = (NUM_DOMAINS == 1) ? RUN : SEQ;
   localparam logic       FIRST_DONE  = (NUM_DOMAINS == 1);

   if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16 || SYNC_STAGES < 2 ||
       FILTER_CYCLES < 1 || RELEASE_GAP < 1 || HOLD_CYCLES < 1) begin : g_illegal_params
      $error("reset_sequencer: illegal parameter value");
   end

   logic [SYNC_STAGES-1:0] sync_chain;
   logic [2:0]             state;
   logic [CW-1:0]          count;
   logic [IW-1:0]          index;
   logic                   soft_req;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   always_comb begin
      soft_req = SoftReset && (state == FILTER || state == SEQ || state == RUN);
   end

   // SYNC leaves on the edge the synchronised release appears, so the filter
   // count starts on the very next edge.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state     <= SYNC;
         count     <= '0;
         index     <= '0;
         SysReset  <= '0;
         ResetDone <= 1'b0;
      end else if (soft_req) begin
         state     <= SOFT_HOLD;
         count     <= '0;
         index     <= '0;
         SysReset  <= '0;
         ResetDone <= 1'b0;
      end else begin
         case (state)
            SYNC: begin
               if (sync_chain[SYNC_STAGES-2]) begin
                  state <= FILTER;
                  count <= '0;
               end
            end
            FILTER: begin
               if (!sync_chain[SYNC_STAGES-1]) begin
                  count <= '0;
               end else if (count == FILTER_LAST) begin
                  SysReset  <= NUM_DOMAINS'(1);
                  ResetDone <= FIRST_DONE;
                  state     <= AFTER_FIRST;
                  index     <= IW'(1);
                  count     <= '0;
               end else begin
                  count <= count + 1'b1;
               end
            end
            SEQ: begin
               if (count == GAP_LAST) begin
                  SysReset <= (SysReset << 1) | NUM_DOMAINS'(1);
                  count    <= '0;
                  index    <= index + 1'b1;
                  if (index == LAST_INDEX) begin
                     ResetDone <= 1'b1;
                     state     <= RUN;
                  end
               end else begin
                  count <= count + 1'b1;
               end
            end
            RUN: begin
               state <= RUN;
            end
            SOFT_HOLD: begin
               if (SoftReset) begin
                  count <= '0;
               end else if (count == HOLD_LAST) begin
                  SysReset  <= NUM_DOMAINS'(1);
                  ResetDone <= FIRST_DONE;
                  state     <= AFTER_FIRST;
                  index     <= IW'(1);
                  count     <= '0;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: begin
               state <= SYNC;
               count <= '0;
            end
         endcase
      end
   end

`ifdef RESET_SEQ_CAUSE_EN
   // 01 = external board reset, 10 = software request; kept until the next reset.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         LastCause <= 2'b01;
      end else if (soft_req) begin
         LastCause <= 2'b10;
      end
   end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 4-domain instance plus a 1-domain,
// 3-stage, 1-cycle-filter instance; expectations are queued per edge and checked as edges occur.
module tb_reset_sequencer;

   logic       Clock;
   logic       Reset;
   logic       soft1;
   logic       soft2;
   logic [3:0] sys1;
   logic       done1;
   logic [0:0] sys2;
   logic       done2;
`ifdef RESET_SEQ_CAUSE_EN
   logic [1:0] cause1;
   logic [1:0] cause2;
`endif

   reset_sequencer dut1 (
      .Reset     (Reset),
      .Clock     (Clock),
      .SoftReset (soft1),
      .SysReset  (sys1),
      .ResetDone (done1)
`ifdef RESET_SEQ_CAUSE_EN
      ,
      .LastCause (cause1)
`endif
   );

   reset_sequencer #(
      .NUM_DOMAINS   (1),
      .SYNC_STAGES   (3),
      .FILTER_CYCLES (1)
   ) dut2 (
      .Reset     (Reset),
      .Clock     (Clock),
      .SoftReset (soft2),
      .SysReset  (sys2),
      .ResetDone (done2)
`ifdef RESET_SEQ_CAUSE_EN
      ,
      .LastCause (cause2)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      string      tag;
      int         cyc;
      bit         sel;
      logic [3:0] sys;
      logic       done;
      logic [1:0] cause;
      bit         has_cause;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   n_checks;
   int   n_errors;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("[TB] FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic pushMain(input string tag, input int c, input logic [3:0] s, input logic d);
      exp_t e;
      e.tag = tag; e.cyc = c; e.sel = 1'b0; e.sys = s; e.done = d;
      e.cause = 2'b00; e.has_cause = 1'b0;
      sb.push_back(e);
   endtask

   task automatic pushSmall(input string tag, input int c, input logic s, input logic d,
                            input logic [1:0] cause);
      exp_t e;
      e.tag = tag; e.cyc = c; e.sel = 1'b1; e.sys = {3'b000, s}; e.done = d;
      e.cause = cause; e.has_cause = 1'b1;
      sb.push_back(e);
   endtask

   task automatic compareEntry(input exp_t e);
      if (!e.sel) begin
         checkOutput({e.tag, "_sys"}, {28'd0, sys1}, {28'd0, e.sys});
         checkOutput({e.tag, "_done"}, {31'd0, done1}, {31'd0, e.done});
      end else begin
         checkOutput({e.tag, "_sys"}, {31'd0, sys2}, {28'd0, e.sys});
         checkOutput({e.tag, "_done"}, {31'd0, done2}, {31'd0, e.done});
`ifdef RESET_SEQ_CAUSE_EN
         if (e.has_cause) checkOutput({e.tag, "_cause"}, {30'd0, cause2}, {30'd0, e.cause});
`endif
      end
   endtask

   // Advance n rising edges, checking every queued expectation due at each edge.
   task automatic applyStimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge Clock);
         #1;
         cyc++;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
               compareEntry(sb[i]);
               sb.delete(i);
            end
         end
      end
   endtask

   initial begin
      int base;
      cyc      = 0;
      n_checks = 0;
      n_errors = 0;
      soft1    = 1'b0;
      soft2    = 1'b0;
      Reset    = 1'b1;
      #1 Reset = 1'b0;

      repeat (3) @(posedge Clock);
      #1;
      checkOutput("in_reset_sys1", {28'd0, sys1}, 32'h0);
      checkOutput("in_reset_done1", {31'd0, done1}, 32'h0);
      checkOutput("in_reset_sys2", {31'd0, sys2}, 32'h0);
`ifdef RESET_SEQ_CAUSE_EN
      checkOutput("in_reset_cause2", {30'd0, cause2}, 32'h1);
`endif

      // Release just before edge 1.
      Reset = 1'b1;
      cyc   = 0;
      pushMain("boot_e5", 5, 4'b0000, 1'b0);
      pushMain("boot_e6", 6, 4'b0001, 1'b0);
      pushMain("boot_e21", 21, 4'b0001, 1'b0);
      pushMain("boot_e22", 22, 4'b0011, 1'b0);
      pushMain("boot_e38", 38, 4'b0111, 1'b0);
      pushMain("boot_e53", 53, 4'b0111, 1'b0);
      pushMain("boot_e54", 54, 4'b1111, 1'b1);
      pushMain("run_e60", 60, 4'b1111, 1'b1);
      pushSmall("small_e3", 3, 1'b0, 1'b0, 2'b01);
      pushSmall("small_e4", 4, 1'b1, 1'b1, 2'b01);
      applyStimulus(60);

      // Software pulse on the single-domain instance.
      soft2 = 1'b1;
      pushSmall("small_soft_e61", 61, 1'b0, 1'b0, 2'b10);
      pushSmall("small_soft_e68", 68, 1'b0, 1'b0, 2'b10);
      pushSmall("small_soft_e69", 69, 1'b1, 1'b1, 2'b10);
      applyStimulus(1);
      soft2 = 1'b0;
      applyStimulus(9);

      // One-cycle software pulse sampled at edge 71.
      soft1 = 1'b1;
      pushMain("pulse_e71", 71, 4'b0000, 1'b0);
      pushMain("pulse_e78", 78, 4'b0000, 1'b0);
      pushMain("pulse_e79", 79, 4'b0001, 1'b0);
      pushMain("pulse_e95", 95, 4'b0011, 1'b0);
      pushMain("pulse_e111", 111, 4'b0111, 1'b0);
      pushMain("pulse_e126", 126, 4'b0111, 1'b0);
      pushMain("pulse_e127", 127, 4'b1111, 1'b1);
      applyStimulus(1);
      soft1 = 1'b0;
      applyStimulus(56);

      // Software request held for 20 samples, edges 128..147.
      soft1 = 1'b1;
      pushMain("hold_e128", 128, 4'b0000, 1'b0);
      pushMain("hold_e147", 147, 4'b0000, 1'b0);
      pushMain("hold_e154", 154, 4'b0000, 1'b0);
      pushMain("hold_e155", 155, 4'b0001, 1'b0);
      pushMain("hold_e202", 202, 4'b0111, 1'b0);
      pushMain("hold_e203", 203, 4'b1111, 1'b1);
      applyStimulus(20);
      soft1 = 1'b0;
      applyStimulus(56);

      // Pulse at 204, then a second request on edge 244 where bit 2 would release.
      soft1 = 1'b1;
      pushMain("clash_e204", 204, 4'b0000, 1'b0);
      pushMain("clash_e243", 243, 4'b0011, 1'b0);
      pushMain("clash_e244", 244, 4'b0000, 1'b0);
      pushMain("clash_e251", 251, 4'b0000, 1'b0);
      pushMain("clash_e252", 252, 4'b0001, 1'b0);
      pushMain("clash_e300", 300, 4'b1111, 1'b1);
      applyStimulus(1);
      soft1 = 1'b0;
      applyStimulus(39);
      soft1 = 1'b1;
      applyStimulus(1);
      soft1 = 1'b0;
      applyStimulus(56);

      // Re-sequence, then glitch the board reset after bit 1 is out.
      soft1 = 1'b1;
      pushMain("glitch_e325", 325, 4'b0011, 1'b0);
      applyStimulus(1);
      soft1 = 1'b0;
      applyStimulus(26);
      Reset = 1'b0;
      #1;
      checkOutput("glitch_async_sys1", {28'd0, sys1}, 32'h0);
      checkOutput("glitch_async_done1", {31'd0, done1}, 32'h0);
      checkOutput("glitch_async_sys2", {31'd0, sys2}, 32'h0);
      Reset = 1'b1;

      // New edge 1 is base+1; a software pulse there lands in SYNC and is ignored.
      base  = cyc;
      soft1 = 1'b1;
      pushMain("restart_e5", base + 5, 4'b0000, 1'b0);
      pushMain("restart_e6", base + 6, 4'b0001, 1'b0);
      pushMain("restart_e21", base + 21, 4'b0001, 1'b0);
      pushMain("restart_e22", base + 22, 4'b0011, 1'b0);
      pushMain("restart_e53", base + 53, 4'b0111, 1'b0);
      pushMain("restart_e54", base + 54, 4'b1111, 1'b1);
      pushSmall("small_restart_e3", base + 3, 1'b0, 1'b0, 2'b01);
      pushSmall("small_restart_e4", base + 4, 1'b1, 1'b1, 2'b01);
      applyStimulus(1);
      soft1 = 1'b0;
      applyStimulus(55);

      checkOutput("scoreboard_drained", sb.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
